// File: rtl/host_uart_pkg.sv
// Shared constants for the host UART response path: 8N1 frame values, packet
// size limit, response IDs and the byte-serialiser state encoding.
package host_uart_pkg;

    localparam logic START     = 1'b0;
    localparam logic STOP      = 1'b1;
    localparam int   DATA_BITS = 8;

    localparam int   MAX_BYTES = 32;

    localparam logic [15:0] ENCRYPT_ENABLE_RSP_ID  = 16'h1;
    localparam logic [15:0] READ_YAW_RSP_ID        = 16'h2;
    localparam logic [15:0] INVALID_COMMAND_RSP_ID = 16'h4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT
    } tx_state_e;

    // Byte k of a packet lives at bits [8k+7:8k].
    function automatic logic [7:0] packet_byte(input logic [8*MAX_BYTES-1:0] pkt,
                                               input logic [4:0]             idx);
        return pkt[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. byte_ready is high in IDLE and in the last cycle of a
// stop bit, so a byte offered then starts its start bit with no idle gap.
module uart_tx_byte
    import host_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx
);

    localparam int unsigned       CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= STOP;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the line value for the state being entered, so tx is registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        byte_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                byte_ready = 1'b1;
                tx_d       = STOP;
                if (byte_valid) begin
                    shift_d = byte_in;
                    cnt_d   = '0;
                    state_d = S_START_BIT;
                    tx_d    = START;
                end
            end
            S_START_BIT: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA_BITS;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA_BITS: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_STOP_BIT;
                        tx_d    = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP_BIT: begin
                byte_ready = bit_end;
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_valid) begin
                        shift_d = byte_in;
                        state_d = S_START_BIT;
                        tx_d    = START;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = STOP;
            end
        endcase
    end

endmodule

// File: rtl/host_uart_packet_tx.sv
// Packet front end for the UART TX line: latches a packet, feeds its bytes to
// the serialiser back-to-back and reports busy, done and length errors.
module host_uart_packet_tx
    import host_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*MAX_BYTES-1:0] packet_data,
    input  logic [5:0]             packet_len,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   tx
);

    localparam logic [5:0] MAX_LEN = 6'(MAX_BYTES);

    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [5:0]             len_q, len_d;
    logic [4:0]             byte_idx_q, byte_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic       len_ok;
    logic       accept;
    logic       last_byte;
    logic       byte_end;
    logic       byte_ready;
    logic       byte_valid;
    logic [7:0] byte_in;

    assign len_ok    = (packet_len != 6'd0) && (packet_len <= MAX_LEN);
    assign accept    = !busy_q && start && len_ok;
    assign last_byte = ({1'b0, byte_idx_q} == (len_q - 6'd1));
    // While busy, byte_ready only rises in the final cycle of a stop bit.
    assign byte_end  = busy_q && byte_ready;

    // The first byte bypasses the latch so tx falls on the accepting edge.
    assign byte_valid = accept || (byte_end && !last_byte);
    assign byte_in    = busy_q ? packet_byte(data_q, byte_idx_q + 5'd1) : packet_data[7:0];

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

    always_comb begin
        data_d     = data_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        if (!busy_q) begin
            if (start) begin
                if (len_ok) begin
                    data_d     = packet_data;
                    len_d      = packet_len;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
        end else if (byte_end) begin
            if (last_byte) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                byte_idx_d = byte_idx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_host_uart_packet_tx.sv
// Bench for host_uart_packet_tx at 4 clocks per bit: drivers push expected
// bytes, done cycles, busy lengths and error cycles; monitors pop and compare.
module tb_host_uart_packet_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic         clk;
    logic         reset;
    logic [255:0] packet_data;
    logic [5:0]   packet_len;
    logic         start;
    logic         busy;
    logic         done;
    logic         error;
    logic         tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 0;

    logic [7:0] exp_q[$];
    int         exp_done_q[$];
    int         exp_busy_q[$];
    int         exp_err_q[$];

    host_uart_packet_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .packet_data(packet_data),
        .packet_len (packet_len),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .tx         (tx)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [FRAME_CYC-1:0] frame_of(input logic [7:0] b);
        logic [FRAME_CYC-1:0] f;
        int fb;
        f = '0;
        for (int s = 0; s < FRAME_CYC; s++) begin
            fb = s / CPB;
            if (fb == 0)      f[s] = 1'b0;
            else if (fb == 9) f[s] = 1'b1;
            else              f[s] = b[fb-1];
        end
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_pkt(input logic [255:0] d, input logic [5:0] len, output int e);
        packet_data = d;
        packet_len  = len;
        start       = 1'b1;
        tick();
        e     = cyc;
        start = 1'b0;
    endtask

    task automatic expect_pkt(input logic [255:0] d, input int len, input int e);
        for (int k = 0; k < len; k++) exp_q.push_back(d[8*k +: 8]);
        exp_done_q.push_back(e + len * FRAME_CYC);
        exp_busy_q.push_back(len * FRAME_CYC);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) fail_now("idle_wait", "busy still high after cycle budget");
    endtask

    // ---------------- frame monitor ----------------
    initial begin : frame_mon
        logic [FRAME_CYC-1:0] obs;
        bit aborted;
        logic [7:0] eb;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                obs     = '0;
                aborted = 0;
                obs[0]  = tx;
                for (int s = 1; s < FRAME_CYC; s++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1;
                        break;
                    end
                    obs[s] = tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame", $sformatf("frame %0h seen, required none", obs));
                    end else begin
                        eb = exp_q.pop_front();
                        chk($sformatf("frame_%02h", eb), 64'(obs), 64'(frame_of(eb)));
                    end
                end
            end
        end
    end

    // ---------------- busy / done / error monitor ----------------
    initial begin : status_mon
        int  busy_run;
        bit  busy_prev;
        busy_run  = 0;
        busy_prev = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_prev) begin
                if (exp_busy_q.size() == 0) fail_now("unexpected_busy", $sformatf("busy run %0d, required none", busy_run));
                else chk("busy_len", 64'(busy_run), 64'(exp_busy_q.pop_front()));
                busy_run = 0;
            end
            busy_prev = (busy === 1'b1);
            if (done === 1'b1) begin
                chk("busy_at_done", 64'(busy), 64'd0);
                if (exp_done_q.size() == 0) fail_now("unexpected_done", "pulse seen, required none");
                else chk("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
            end
            if (error === 1'b1) begin
                if (exp_err_q.size() == 0) fail_now("unexpected_error", "pulse seen, required none");
                else chk("error_cycle", 64'(cyc), 64'(exp_err_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int e, e2;
        logic [255:0] d;
        reset       = 1'b1;
        start       = 1'b0;
        packet_data = '0;
        packet_len  = '0;
        repeat (3) tick();
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset  = 1'b0;
        mon_en = 1;
        tick();

        // 1: four-byte packet
        d = 256'h04030201;
        start_pkt(d, 6'd4, e);
        expect_pkt(d, 4, e);
        chk("t1_tx_fall", 64'(tx), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_idle(400);
        tick();
        chk("t1_tx_idle", 64'(tx), 64'd1);

        // 2: illegal lengths
        start_pkt(256'hAB, 6'd0, e);
        exp_err_q.push_back(e);
        chk("t2_len0_busy", 64'(busy), 64'd0);
        chk("t2_len0_tx", 64'(tx), 64'd1);
        tick();
        start_pkt(256'hAB, 6'd33, e);
        exp_err_q.push_back(e);
        chk("t2_len33_busy", 64'(busy), 64'd0);
        chk("t2_len33_tx", 64'(tx), 64'd1);
        chk("t2_len33_done", 64'(done), 64'd0);
        repeat (3) tick();

        // 3: start while busy is ignored
        d = 256'h3C;
        start_pkt(d, 6'd1, e);
        expect_pkt(d, 1, e);
        repeat (19) tick();
        start_pkt(256'hC7C6, 6'd2, e2);
        chk("t3_ignored_busy", 64'(busy), 64'd1);
        chk("t3_ignored_err", 64'(error), 64'd0);
        wait_idle(200);
        repeat (3) tick();

        // simultaneous reset and start: reset wins
        reset       = 1'b1;
        packet_data = 256'h99;
        packet_len  = 6'd1;
        start       = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        chk("rst_start_tx", 64'(tx), 64'd1);
        tick();
        chk("rst_start_busy2", 64'(busy), 64'd0);

        // 4: reset at cycle 50 of a two-byte packet
        d = 256'hC35A;
        start_pkt(d, 6'd2, e);
        exp_q.push_back(8'h5A);
        exp_busy_q.push_back(50);
        repeat (49) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_tx", 64'(tx), 64'd1);
        chk("t4_rst_busy", 64'(busy), 64'd0);
        chk("t4_rst_done", 64'(done), 64'd0);
        repeat (2) tick();
        d = 256'h96;
        start_pkt(d, 6'd1, e);
        expect_pkt(d, 1, e);
        wait_idle(200);
        repeat (3) tick();

        // 5: full-length packet, last byte zero
        d = {8'h00, {31{8'hFF}}};
        start_pkt(d, 6'd32, e);
        expect_pkt(d, 32, e);
        wait_idle(2000);
        repeat (3) tick();

        // 6: start in the done cycle
        d = 256'h81;
        start_pkt(d, 6'd1, e);
        expect_pkt(d, 1, e);
        repeat (FRAME_CYC) tick();
        chk("t6_done_now", 64'(done), 64'd1);
        d = 256'hA5;
        start_pkt(d, 6'd1, e2);
        expect_pkt(d, 1, e2);
        chk("t6_tx_fall", 64'(tx), 64'd0);
        chk("t6_busy", 64'(busy), 64'd1);
        wait_idle(200);
        repeat (10) tick();

        chk("left_frames", 64'(exp_q.size()), 64'd0);
        chk("left_done", 64'(exp_done_q.size()), 64'd0);
        chk("left_busy", 64'(exp_busy_q.size()), 64'd0);
        chk("left_error", 64'(exp_err_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/host_uart_packet_tx.md
Name: host_uart_packet_tx

Overview:
Downstream stage of the host UART response encoder. It latches the encoder's 256-bit packet and a byte count, then serialises the bytes onto the host UART TX line as 8N1 frames. It reports completion, busy and length errors back to the command controller that sequences the encoder.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range is ≥ 2.
MAX_BYTES, 32, maximum packet length in bytes; equals packet_data width / 8.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
packet_data  input  256  encoded packet; byte k = packet_data[8k+7:8k]
packet_len  input  6  number of bytes to send, legal 1..MAX_BYTES
start  input  1  single-cycle request; sampled only in IDLE
busy  output  1  high while a packet is being transmitted
done  output  1  one-cycle pulse when the last stop bit completes
error  output  1  one-cycle pulse when start arrives with an illegal packet_len
tx  output  1  UART serial line; idles high

Behaviour:
- Reset: synchronous, active-high. At the reset clock edge, outputs go to tx=1, busy=0, done=0, error=0. The FSM goes to IDLE. Internal counters and the packet latch are cleared.
- Reset mid-frame: tx returns high at that edge. No done or error pulse is issued. A partial frame is abandoned.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE, start=1, packet_len in 1..MAX_BYTES: at that edge the block latches packet_data and packet_len, sets byte_idx=0, busy=1, tx=0, and moves to START_BIT. tx falls one cycle after start is sampled (registered output).
- IDLE, start=1, packet_len=0 or >MAX_BYTES: error=1 for exactly one cycle. The block stays in IDLE, tx stays 1 and busy stays 0.
- start while busy: ignored. No error is raised and the latched data is unaffected.
- Baud counter: every bit is held for exactly CLKS_PER_BIT cycles. The counter runs from 0 to CLKS_PER_BIT-1 and wraps at each bit boundary.
- START_BIT: tx=0 → DATA_BITS, bit_idx=0.
- DATA_BITS: tx carries the current byte LSB-first, bit_idx 0..7. After bit 7 → STOP_BIT.
- STOP_BIT: tx=1. At the end of the stop bit:
  - if byte_idx < len-1: byte_idx increments and the FSM goes → START_BIT immediately, with no extra idle bit.
  - else: → IDLE with done=1 for one cycle and busy=0 in that same cycle.
- Packet duration: with start sampled at edge N, done is high for the cycle following edge N + len·10·CLKS_PER_BIT. busy is high for exactly len·10·CLKS_PER_BIT cycles.
- Back-to-back: a start in the same cycle that done is high is accepted, because the FSM is already in IDLE. The next start bit begins one cycle later.
- Simultaneous reset and start: reset wins and start is discarded.
- Width rules: byte_idx is 5 bits; bit_idx is 3 bits. The baud counter width is $clog2(CLKS_PER_BIT).

Decomposition:
- Shared package (host_uart_pkg) holds:
  - the UART frame constants: START=0, STOP=1, DATA_BITS=8;
  - MAX_BYTES;
  - the response ID constants ENCRYPT_ENABLE_RSP_ID=16'h1, READ_YAW_RSP_ID=16'h2, INVALID_COMMAND_RSP_ID=16'h4, so that the encoder and controller use the same values.
- Sub-module uart_tx_byte (ports: clk, reset, byte_in, byte_valid, byte_ready, tx) owns the baud counter and the bit FSM.
- host_uart_packet_tx keeps the packet latch, byte index, length check and done/error generation.

Test Plan:
Benches use CLKS_PER_BIT=4.
1. Reset, then packet_data=32'h04030201, len=4, start pulse → tx carries bytes 01,02,03,04, LSB-first, each framed 0 + data + 1 at 4 cycles per bit. busy=1 for 160 cycles, done pulses once, tx ends high.
2. start with len=0, then with len=33 → one error pulse each; busy, tx and done unchanged.
3. Second start 20 cycles into a len=1 packet with different data → ignored. Only the first byte appears on tx, and a single done pulse follows after 40 busy cycles.
4. Assert reset at cycle 50 of a len=2 packet → tx=1, busy=0 at the next edge with no done pulse. A new len=1 start then sends correctly.
5. len=32, all-ones data except byte31=8'h00 → 1280 busy cycles; the last frame on tx is 0,00000000,1; done pulses once.
6. Issue start in the done cycle with len=1, data=8'hA5 → accepted; tx falls on the next cycle and carries bits 1,0,1,0,0,1,0,1.
